// File: rtl/multiport_psram_arbiter_if.sv
// Client-side and controller-side signal bundle for the PSRAM port arbiter.
// slave = arbiter view, master = clients plus controller view.
interface multiport_psram_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 23
);
  logic [N_PORTS-1:0]        app_req;
  logic [N_PORTS*DATA_W-1:0] app_data_wr;
  logic [N_PORTS*ADDR_W-1:0] app_addr_in;
  logic [N_PORTS-1:0]        app_wr_in;
  logic [N_PORTS-1:0]        app_rd_in;
  logic [N_PORTS-1:0]        app_ub_in;
  logic [N_PORTS-1:0]        app_lb_in;
  logic [N_PORTS-1:0]        app_burst_in;
  logic [N_PORTS-1:0]        app_data_ok;
  logic [N_PORTS-1:0]        app_op_begun;
  logic [N_PORTS-1:0]        app_op_finished;
  logic [N_PORTS-1:0]        app_grant;
  logic                      data_ok;
  logic                      op_begun;
  logic                      op_finished;
  logic [DATA_W-1:0]         app_data_out;
  logic [ADDR_W-1:0]         app_addr;
  logic                      app_wr;
  logic                      app_rd;
  logic                      app_ub;
  logic                      app_lb;
  logic                      app_burst;
  logic                      busy;
  logic                      timeout_err;

  modport slave (
    input  app_req, app_data_wr, app_addr_in,
    input  app_wr_in, app_rd_in, app_ub_in,
    input  app_lb_in, app_burst_in,
    input  data_ok, op_begun, op_finished,
    output app_data_ok, app_op_begun,
    output app_op_finished, app_grant,
    output app_data_out, app_addr,
    output app_wr, app_rd, app_ub, app_lb,
    output app_burst, busy, timeout_err
  );

  modport master (
    output app_req, app_data_wr, app_addr_in,
    output app_wr_in, app_rd_in, app_ub_in,
    output app_lb_in, app_burst_in,
    output data_ok, op_begun, op_finished,
    input  app_data_ok, app_op_begun,
    input  app_op_finished, app_grant,
    input  app_data_out, app_addr,
    input  app_wr, app_rd, app_ub, app_lb,
    input  app_burst, busy, timeout_err
  );
endinterface

// File: rtl/multiport_psram_arbiter.sv
// N-port arbiter/mux in front of the PSRAM controller op interface.
// Ownership is released on the registered op_finished to avoid a loop.
module multiport_psram_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 23,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0,
  parameter int IDX_W   = 3
) (
  input  logic clk,
  input  logic reset,
  multiport_psram_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_last;
  logic [CNT_W-1:0]   r_hold;
  logic               r_fin_q;
  logic               r_tmo_err;
  logic               w_tmo;
  logic               w_any;
  logic               w_route;
  logic [IDX_W-1:0]   w_fp;
  logic [IDX_W-1:0]   w_rr;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_sel;
  logic [N_PORTS-1:0] w_above;
  logic [N_PORTS-1:0] w_masked;

  assign w_any = |bus.app_req;

  // Round robin: lowest request above rr_last, else wrap to lowest overall.
  always_comb begin
    w_above = '0;
    w_fp    = '0;
    w_rr    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_above[i] = IDX_W'(i) > r_rr_last;
    end
    w_masked = bus.app_req & w_above;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bus.app_req[i]) w_fp = IDX_W'(i);
      if (w_masked[i])    w_rr = IDX_W'(i);
    end
    w_winner = ((RR_MODE != 0) && (|w_masked)) ? w_rr : w_fp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr_last <= IDX_W'(N_PORTS - 1);
      r_hold    <= '0;
      r_fin_q   <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_fin_q   <= bus.op_finished;
      r_tmo_err <= w_tmo;
      if (r_state == S_IDLE && w_any) begin
        r_owner   <= w_winner;
        r_rr_last <= w_winner;
        r_hold    <= '0;
      end else if (r_state == S_GRANT && r_hold != '1) begin
        r_hold <= r_hold + CNT_W'(1);
      end
    end
  end

  // A finish seen in the same cycle as the limit wins; no error then.
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_GRANT;
      end
      S_GRANT: begin
        if (r_fin_q) begin
          w_next = S_IDLE;
        end else if (TIMEOUT != 0 &&
                     r_hold == CNT_W'(TIMEOUT - 1)) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sel   = (r_state == S_GRANT) ? r_owner : w_winner;
  assign w_route = (r_state == S_GRANT) || w_any;

  always_comb begin
    bus.app_data_out    = '0;
    bus.app_addr        = '0;
    bus.app_wr          = 1'b0;
    bus.app_rd          = 1'b0;
    bus.app_ub          = 1'b0;
    bus.app_lb          = 1'b0;
    bus.app_burst       = 1'b0;
    bus.app_data_ok     = '0;
    bus.app_op_begun    = '0;
    bus.app_op_finished = '0;
    bus.app_grant       = '0;
    bus.busy            = (r_state == S_GRANT);
    bus.timeout_err     = r_tmo_err;
    if (!reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_sel == IDX_W'(i)) begin
          bus.app_data_out = bus.app_data_wr[i*DATA_W +: DATA_W];
          bus.app_addr     = bus.app_addr_in[i*ADDR_W +: ADDR_W];
          bus.app_wr       = bus.app_wr_in[i] & w_route;
          bus.app_rd       = bus.app_rd_in[i] & w_route;
          bus.app_ub       = bus.app_ub_in[i];
          bus.app_lb       = bus.app_lb_in[i];
          bus.app_burst    = bus.app_burst_in[i];
          bus.app_data_ok[i]  = bus.data_ok & w_route;
          bus.app_op_begun[i] = bus.op_begun & w_route;
        end
        if (r_state == S_GRANT && r_owner == IDX_W'(i)) begin
          bus.app_op_finished[i] = bus.op_finished;
          bus.app_grant[i]       = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multiport_psram_arbiter.sv
// Bench: round-robin/timeout and fixed-priority instances on shared stimulus,
// checked every cycle against a behavioural model plus literal scenarios.
module tb_multiport_psram_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 23;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, wr_in, rd_in, ub_in, lb_in, burst_in;
  logic [N*DW-1:0] wdata;
  logic [N*AW-1:0] addr_in;
  logic            data_ok, op_begun, op_finished;

  logic [1:0][N-1:0]  g_grant, g_dok, g_obeg, g_ofin;
  logic [1:0][AW-1:0] g_addr;
  logic [1:0][DW-1:0] g_data;
  logic [1:0]         g_busy, g_err, g_wr, g_rd, g_ub, g_lb, g_burst;

  multiport_psram_arbiter_if #(.N_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) ifs[2] ();

  for (genvar g = 0; g < 2; g++) begin : g_inst
    assign ifs[g].app_req      = req;
    assign ifs[g].app_data_wr  = wdata;
    assign ifs[g].app_addr_in  = addr_in;
    assign ifs[g].app_wr_in    = wr_in;
    assign ifs[g].app_rd_in    = rd_in;
    assign ifs[g].app_ub_in    = ub_in;
    assign ifs[g].app_lb_in    = lb_in;
    assign ifs[g].app_burst_in = burst_in;
    assign ifs[g].data_ok      = data_ok;
    assign ifs[g].op_begun     = op_begun;
    assign ifs[g].op_finished  = op_finished;
    assign g_grant[g] = ifs[g].app_grant;
    assign g_dok[g]   = ifs[g].app_data_ok;
    assign g_obeg[g]  = ifs[g].app_op_begun;
    assign g_ofin[g]  = ifs[g].app_op_finished;
    assign g_addr[g]  = ifs[g].app_addr;
    assign g_data[g]  = ifs[g].app_data_out;
    assign g_busy[g]  = ifs[g].busy;
    assign g_err[g]   = ifs[g].timeout_err;
    assign g_wr[g]    = ifs[g].app_wr;
    assign g_rd[g]    = ifs[g].app_rd;
    assign g_ub[g]    = ifs[g].app_ub;
    assign g_lb[g]    = ifs[g].app_lb;
    assign g_burst[g] = ifs[g].app_burst;

    multiport_psram_arbiter #(
      .N_PORTS(N), .DATA_W(DW), .ADDR_W(AW),
      .RR_MODE(g == 0 ? 1 : 0),
      .TIMEOUT(g == 0 ? 8 : 0),
      .IDX_W(IW)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(ifs[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int m,
                     input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, m, got, exp, $time);
    end
  endtask

  // Behavioural model: inst 0 = round robin + timeout 8, inst 1 = fixed priority.
  bit m_busy[2], m_fin[2], m_err[2];
  int m_owner[2], m_last[2], m_cnt[2];

  function automatic int winner(input int m);
    if (m == 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last[m] + k) % N;
        if (req[j]) return j;
      end
    end else begin
      for (int j = 0; j < N; j++) if (req[j]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_busy[m] = 0; m_fin[m] = 0; m_err[m] = 0;
        m_owner[m] = 0; m_last[m] = N - 1; m_cnt[m] = 0;
      end else begin
        int lim;
        lim = (m == 0) ? 8 : 0;
        m_err[m] = 0;
        if (!m_busy[m]) begin
          if (|req) begin
            m_owner[m] = winner(m);
            m_last[m]  = m_owner[m];
            m_busy[m]  = 1;
            m_cnt[m]   = 0;
          end
        end else if (m_fin[m]) begin
          m_busy[m] = 0;
        end else if (lim != 0 && m_cnt[m] == lim - 1) begin
          m_busy[m] = 0;
          m_err[m]  = 1;
        end else begin
          m_cnt[m]++;
        end
        m_fin[m] = op_finished;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        bit act;
        int sel;
        logic [N-1:0] e_g, e_dok, e_obeg, e_ofin;
        act = m_busy[m] || (|req);
        sel = m_busy[m] ? m_owner[m] : winner(m);
        e_g = '0; e_dok = '0; e_obeg = '0; e_ofin = '0;
        if (m_busy[m]) begin
          e_g[m_owner[m]]    = 1'b1;
          e_ofin[m_owner[m]] = op_finished;
        end
        if (act) begin
          e_dok[sel]  = data_ok;
          e_obeg[sel] = op_begun;
        end
        chk("grant", m, g_grant[m], e_g);
        chk("busy", m, g_busy[m], m_busy[m]);
        chk("tmo_err", m, g_err[m], m_err[m]);
        chk("wr", m, g_wr[m], act ? wr_in[sel] : 1'b0);
        chk("rd", m, g_rd[m], act ? rd_in[sel] : 1'b0);
        chk("data_ok", m, g_dok[m], e_dok);
        chk("op_begun", m, g_obeg[m], e_obeg);
        chk("op_fin", m, g_ofin[m], e_ofin);
        if (act) begin
          chk("addr", m, g_addr[m], addr_in[sel*AW +: AW]);
          chk("wdata", m, g_data[m], wdata[sel*DW +: DW]);
          chk("ub", m, g_ub[m], ub_in[sel]);
          chk("lb", m, g_lb[m], lb_in[sel]);
          chk("burst", m, g_burst[m], burst_in[sel]);
        end
      end
    end
  end

  // Grant-order recorder for the literal sequence checks.
  int q0[$], q1[$];
  bit prev_b[2];
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (g_busy[m] && !prev_b[m]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < N; i++) if (g_grant[m][i]) idx = i;
        if (m == 0) q0.push_back(idx);
        else q1.push_back(idx);
      end
      prev_b[m] = g_busy[m];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int m, input bit v, input string nm);
    for (int i = 0; i < 30 && g_busy[m] !== v; i++) cyc();
    chk(nm, m, g_busy[m], v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_ops(input int n);
    for (int k = 0; k < n; k++) begin
      wait_busy(0, 1'b1, "wait_grant");
      cyc();
      op_finished = 1'b1;
      if (k == n - 1) req = '0;
      cyc();
      op_finished = 1'b0;
      wait_busy(0, 1'b0, "wait_release");
    end
  endtask

  task automatic chk_seq(input string nm, input int m, input int exp[5],
                         input int n);
    int sz;
    sz = (m == 0) ? q0.size() : q1.size();
    chk({nm, "_len"}, m, sz, n);
    for (int k = 0; k < n; k++) begin
      int got;
      got = -1;
      if (k < sz) got = (m == 0) ? q0[k] : q1[k];
      chk(nm, m, got, exp[k]);
    end
  endtask

  initial begin
    int cnt_b, cnt_e;
    req = '0; wr_in = '0; rd_in = '0; ub_in = '0; lb_in = '0;
    burst_in = '0; wdata = '0; addr_in = '0;
    data_ok = 0; op_begun = 0; op_finished = 0;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_grant", m, g_grant[m], 0);
      chk("rst_busy", m, g_busy[m], 0);
      chk("rst_err", m, g_err[m], 0);
    end

    // Zero-latency presentation, then registered grant.
    cyc();
    req = 4'b0100;
    rd_in = 4'b0100;
    addr_in[2*AW +: AW] = 23'h001234;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t1_addr", m, g_addr[m], 23'h001234);
      chk("t1_rd", m, g_rd[m], 1);
      chk("t1_grant0", m, g_grant[m], 0);
    end
    cyc();
    for (int m = 0; m < 2; m++) begin
      chk("t1_grant", m, g_grant[m], 4'b0100);
      chk("t1_busy", m, g_busy[m], 1);
    end
    req = '0; rd_in = '0;
    op_finished = 1'b1;
    cyc();
    op_finished = 1'b0;
    wait_busy(0, 1'b0, "t1_rel");

    // Round robin vs fixed priority under all-request.
    do_reset();
    q0.delete(); q1.delete();
    req = 4'b1111;
    run_ops(5);
    chk_seq("t2_rr_order", 0, '{0, 1, 2, 3, 0}, 5);
    chk_seq("t2_fp_order", 1, '{0, 0, 0, 0, 0}, 5);

    q0.delete(); q1.delete();
    req = 4'b1010;
    run_ops(4);
    chk_seq("t3_rr_order", 0, '{1, 3, 1, 3, 0}, 4);
    chk_seq("t3_fp_order", 1, '{1, 1, 1, 1, 0}, 4);

    // Hold timeout on the round-robin instance only.
    req = 4'b0100;
    wait_busy(0, 1'b1, "t4_grant");
    req = '0;
    cnt_b = 0; cnt_e = 0;
    for (int i = 0; i < 20; i++) begin
      if (g_busy[0]) cnt_b++;
      if (g_err[0]) cnt_e++;
      cyc();
    end
    chk("t4_busy_cycles", 0, cnt_b, 8);
    chk("t4_err_pulses", 0, cnt_e, 1);
    chk("t4_grant_after", 0, g_grant[0], 0);
    chk("t4_fp_still", 1, g_busy[1], 1);
    op_finished = 1'b1;
    cyc();
    op_finished = 1'b0;
    wait_busy(1, 1'b0, "t4_fp_rel");
    cyc();

    // Status routing to owner port 0 only.
    req = 4'b0001;
    wait_busy(0, 1'b1, "t5_grant");
    req = '0;
    data_ok = 1; op_begun = 1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t5_dok", m, g_dok[m], 4'b0001);
      chk("t5_obeg", m, g_obeg[m], 4'b0001);
    end
    cyc();
    data_ok = 0; op_begun = 1;
    #1;
    chk("t5_dok_lo", 0, g_dok[0], 4'b0000);
    chk("t5_obeg_hi", 0, g_obeg[0], 4'b0001);
    op_begun = 0;
    op_finished = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) chk("t5_ofin", m, g_ofin[m], 4'b0001);
    cyc();
    op_finished = 1'b0;
    wait_busy(0, 1'b0, "t5_rel");

    // Asynchronous reset mid-grant, then fresh arbitration.
    req = 4'b1111; wr_in = 4'b1111; rd_in = 4'b1111;
    wait_busy(0, 1'b1, "t6_grant");
    #2 reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t6_grant", m, g_grant[m], 0);
      chk("t6_busy", m, g_busy[m], 0);
      chk("t6_wr", m, g_wr[m], 0);
      chk("t6_rd", m, g_rd[m], 0);
    end
    cyc();
    reset = 1'b0;
    cyc();
    for (int m = 0; m < 2; m++) chk("t6_first", m, g_grant[m], 4'b0001);
    req = '0; wr_in = '0; rd_in = '0;
    op_finished = 1'b1;
    cyc();
    op_finished = 1'b0;
    cyc();
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      wr_in = N'($urandom); rd_in = N'($urandom);
      ub_in = N'($urandom); lb_in = N'($urandom);
      burst_in = N'($urandom);
      for (int p = 0; p < N; p++) begin
        addr_in[p*AW +: AW] = AW'($urandom);
        wdata[p*DW +: DW]   = DW'($urandom);
      end
      data_ok     = 1'($urandom);
      op_begun    = 1'($urandom);
      op_finished = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) chk("rnd_rst_busy", m, g_busy[m], 0);
        cyc();
        reset = 1'b0;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
